// File: rtl/pipe_kogge_stone_nbit.sv
// rtl/pipe_kogge_stone_nbit.sv - fully pipelined bw-bit Kogge-Stone adder, one prefix level per stage
// Latency is log2(bw)+3 edges; result stream is time-aligned with the operand stream.
module pipe_kogge_stone_nbit #(
  parameter int bw = 32
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic [bw:1]   A,
  input  logic [bw:1]   B,
  input  logic          cin,
  output logic [bw:1]   sum,
  output logic          cout
);

  localparam int L = $clog2(bw);

  logic [bw:1] a_r, b_r;
  logic        cin_r;

  // Index 0 is the generate/propagate stage; index k holds the result of prefix level k.
  logic [bw:1] gg   [0:L];
  logic [bw:1] pp   [0:L];
  logic [bw:1] praw [0:L];
  logic        cc   [0:L];

  logic [bw:1] g0_nxt;

  always_comb begin
    g0_nxt    = a_r & b_r;
    g0_nxt[1] = (a_r[1] & b_r[1]) | ((a_r[1] ^ b_r[1]) & cin_r);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      a_r     <= '0;
      b_r     <= '0;
      cin_r   <= 1'b0;
      gg[0]   <= '0;
      pp[0]   <= '0;
      praw[0] <= '0;
      cc[0]   <= 1'b0;
    end else begin
      a_r     <= A;
      b_r     <= B;
      cin_r   <= cin;
      gg[0]   <= g0_nxt;
      pp[0]   <= a_r ^ b_r;
      praw[0] <= a_r ^ b_r;
      cc[0]   <= cin_r;
    end
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    logic [bw:1] g_nxt, p_nxt;

    // Bits at or below the span already hold their final group generate.
    always_comb begin
      g_nxt = gg[k-1];
      p_nxt = pp[k-1];
      for (int i = D + 1; i <= bw; i++) begin
        g_nxt[i] = gg[k-1][i] | (pp[k-1][i] & gg[k-1][i-D]);
        p_nxt[i] = pp[k-1][i] & pp[k-1][i-D];
      end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        gg[k]   <= '0;
        pp[k]   <= '0;
        praw[k] <= '0;
        cc[k]   <= 1'b0;
      end else begin
        gg[k]   <= g_nxt;
        pp[k]   <= p_nxt;
        praw[k] <= praw[k-1];
        cc[k]   <= cc[k-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= praw[L] ^ {gg[L][bw-1:1], cc[L]};
      cout <= gg[L][bw];
    end
  end

endmodule

// File: tb/tb_pipe_kogge_stone_nbit.sv
// tb/tb_pipe_kogge_stone_nbit.sv - scoreboard bench for pipe_kogge_stone_nbit at bw=32
module tb_pipe_kogge_stone_nbit;

  localparam int BW  = 32;
  localparam int LAT = 8;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic [BW:1]   A, B;
  logic          cin;
  logic [BW:1]   sum;
  logic          cout;

  int checks = 0;
  int errors = 0;
  logic [BW:0] sb [$];

  pipe_kogge_stone_nbit #(.bw(BW)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .A      (A),
    .B      (B),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [BW:0] obs, input logic [BW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive operands, let one rising edge capture them, check output.
  task automatic step(input logic [BW:1] a, input logic [BW:1] b, input logic c, input string tag);
    logic [BW:0] exp;
    A = a; B = b; cin = c;
    @(posedge CLK);
    sb.push_back({1'b0, a} + {1'b0, b} + {{BW{1'b0}}, c});
    #1;
    if (sb.size() == LAT) exp = sb.pop_front();
    else exp = '0;
    chk(tag, {cout, sum}, exp);
    @(negedge CLK);
  endtask

  initial begin
    RESETn = 1'b1;
    A = 32'h1234_5678; B = 32'h0f0f_0f0f; cin = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1 RESETn = 1'b0;
    #1 chk("async_reset_initial", {cout, sum}, '0);
    @(posedge CLK);
    #1 chk("reset_held", {cout, sum}, '0);
    @(negedge CLK);
    RESETn = 1'b1;

    repeat (10) step(32'd30000, 32'd50000, 1'b0, "held_30000_50000");
    step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ripple_all_ones_cin");
    step(32'h8000_0000, 32'h8000_0000, 1'b0, "msb_plus_msb");
    step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "to_msb");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "max_max_cin");
    step(32'h0000_0000, 32'h0000_0000, 1'b1, "zero_cin");
    step(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, "alt_bits");
    step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, "alt_bits_cin");

    for (int n = 0; n < 1000; n++)
      step($urandom, $urandom, 1'($urandom_range(0, 1)), "random_stream");

    // Mid-stream reset: pipeline is full of in-flight operands at this point.
    A = 32'hDEAD_BEEF; B = 32'h1111_1111; cin = 1'b1;
    #2 RESETn = 1'b0;
    #1 chk("async_reset_midstream", {cout, sum}, '0);
    @(posedge CLK);
    #1 chk("reset_midstream_held", {cout, sum}, '0);
    sb.delete();
    @(negedge CLK);
    RESETn = 1'b1;

    for (int n = 0; n < 20; n++)
      step($urandom, $urandom, 1'($urandom_range(0, 1)), "post_reset_stream");
    for (int n = 0; n < LAT; n++)
      step(32'h0, 32'h0, 1'b0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
